// File: rtl/raw_capture_pkg.sv
// Shared types and sizing for the raw Bayer frame capture block.
package raw_capture_pkg;

    localparam int unsigned ADDR_W      = 19;
    localparam int unsigned X_W         = 10;
    localparam int unsigned Y_W         = 9;
    localparam int unsigned PIX_W       = 10;
    localparam int unsigned DEF_FRAME_W = 640;
    localparam int unsigned DEF_FRAME_H = 480;
    localparam int unsigned FRAME_LEN   = DEF_FRAME_W * DEF_FRAME_H;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } cap_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } pix_wr_t;

    function automatic int unsigned frame_len(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/raw_frame_capture_pixel_pos_counter.sv
// x/y pixel position with an incrementally maintained linear address y*FRAME_W+x.
module pixel_pos_counter
    import raw_capture_pkg::*;
#(
    parameter int unsigned FRAME_W = DEF_FRAME_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              inc_x,
    input  logic              next_line,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(FRAME_W);

    logic [ADDR_W-1:0] line_base;

    // Line base advances by FRAME_W per line, so no multiplier is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            line_base <= '0;
        end else if (clear) begin
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            line_base <= '0;
        end else if (next_line) begin
            x         <= '0;
            y         <= y + Y_W'(1);
            line_base <= line_base + LINE_STEP;
            addr      <= line_base + LINE_STEP;
        end else if (inc_x) begin
            x         <= x + X_W'(1);
            addr      <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/raw_frame_capture.sv
// Captures one raw camera frame on request and streams it to a frame buffer.
module raw_frame_capture
    import raw_capture_pkg::*;
#(
    parameter int unsigned FRAME_W = DEF_FRAME_W,
    parameter int unsigned FRAME_H = DEF_FRAME_H
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [PIX_W-1:0]  cam_data,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [PIX_W-1:0]  raw_data,
    output logic              busy,
    output logic              finished,
    output logic              frame_err
);

    localparam logic [X_W-1:0]    LINE_LEN  = X_W'(FRAME_W);
    localparam logic [Y_W-1:0]    LAST_LINE = Y_W'(FRAME_H - 1);
    localparam logic [ADDR_W-1:0] ADDR_END  = ADDR_W'(frame_len(FRAME_W, FRAME_H));

    logic [1:0]        rst_sync;
    logic              rst_n_int;
    logic              vsync_q, vsync_p, href_q, href_p;
    logic [PIX_W-1:0]  data_q;
    logic              vsync_fall, vsync_rise, href_fall;
    cap_state_e        state_q, state_d;
    logic              inc_x, next_line, cnt_clear;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addr;
    pix_wr_t           wr_q, wr_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    // Asynchronous assert, two-flop synchronised release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n_int = rst_sync[1];

    // Camera inputs registered once, then delayed once more for edge detection.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            vsync_q <= 1'b0;
            vsync_p <= 1'b0;
            href_q  <= 1'b0;
            href_p  <= 1'b0;
            data_q  <= '0;
        end else begin
            vsync_q <= cam_vsync;
            vsync_p <= vsync_q;
            href_q  <= cam_href;
            href_p  <= href_q;
            data_q  <= cam_data;
        end
    end

    assign vsync_fall = vsync_p & ~vsync_q;
    assign vsync_rise = vsync_q & ~vsync_p;
    assign href_fall  = href_p & ~href_q;
    assign cnt_clear  = (state_q != CAPTURE);

    pixel_pos_counter #(
        .FRAME_W(FRAME_W)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n_int),
        .clear    (cnt_clear),
        .inc_x    (inc_x),
        .next_line(next_line),
        .x        (x),
        .y        (y),
        .addr     (addr)
    );

    always_comb begin
        state_d   = state_q;
        inc_x     = 1'b0;
        next_line = 1'b0;
        we_d      = 1'b0;
        wr_d      = wr_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ARM;
            end
            ARM: begin
                if (vsync_fall) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (vsync_rise) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (href_q) begin
                    // Overlong lines are dropped past FRAME_W rather than wrapped.
                    if (x < LINE_LEN && addr < ADDR_END) begin
                        we_d      = 1'b1;
                        wr_d.addr = addr;
                        wr_d.data = data_q;
                        inc_x     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (href_fall) begin
                    next_line = 1'b1;
                    if (x != LINE_LEN) err_d = 1'b1;
                    if (y == LAST_LINE) state_d = DONE;
                end
            end
            DONE: begin
                if (start) state_d = ARM;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == ARM && state_q != ARM) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            wr_q     <= '0;
            err_q    <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            busy     <= (state_d == ARM) || (state_d == CAPTURE);
            finished <= (state_d == DONE);
        end
    end

    assign write_en   = we_q;
    assign write_addr = wr_q.addr;
    assign raw_data   = wr_q.data;
    assign frame_err  = err_q;

endmodule

// File: doc/raw_frame_capture.md
RAW_FRAME_CAPTURE -- requirements
Module: raw_frame_capture

Interface
REQ-001 SHALL have parameter FRAME_W, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter FRAME_H, default 480, meaning active lines per frame.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to arm capture of the next frame.
REQ-006 SHALL have port cam_vsync, input, 1 bit: frame sync; high marks the vertical blank.
REQ-007 SHALL have port cam_href, input, 1 bit: line valid; high means cam_data holds an active pixel.
REQ-008 SHALL have port cam_data, input, 10 bits: raw Bayer pixel.
REQ-009 SHALL have port write_en, output, 1 bit: frame-buffer write strobe.
REQ-010 SHALL have port write_addr, output, 19 bits: linear pixel address, y*FRAME_W+x.
REQ-011 SHALL have port raw_data, output, 10 bits: pixel written at write_addr.
REQ-012 SHALL have port busy, output, 1 bit: high while armed or capturing.
REQ-013 SHALL have port finished, output, 1 bit: level signal, high once a frame has ended; this is the frame-ready signal for the raw-to-gray converter.
REQ-014 SHALL have port frame_err, output, 1 bit: the last frame had a line-length or line-count mismatch.

Function
REQ-015 SHALL implement the FSM states IDLE, ARM, CAPTURE and DONE.
REQ-016 IDLE->ARM on start=1; DONE->ARM on start=1; start SHALL be ignored in ARM and CAPTURE.
REQ-017 ARM->CAPTURE on the first cycle where cam_vsync is sampled 1 then 0 (falling edge); a frame already in progress when start arrives SHALL NOT be captured.
REQ-018 CAPTURE: each cycle with cam_href=1 and x<FRAME_W SHALL register write_en=1, raw_data=cam_data and write_addr=y*FRAME_W+x, then increment x.
REQ-019 Write latency SHALL be exactly 1 cycle from cam_href/cam_data sampling to write_en/raw_data/write_addr.
REQ-020 On a cam_href falling edge in CAPTURE: x resets to 0 and y increments; frame_err is set if x != FRAME_W.
REQ-021 Pixels with x>=FRAME_W on one line SHALL be dropped (no write) and frame_err set.
REQ-022 CAPTURE->DONE when y reaches FRAME_H (after the last line's href fall), or when cam_vsync rises early; an early rise sets frame_err.
REQ-023 No write SHALL ever occur with write_addr >= FRAME_W*FRAME_H.
REQ-024 DONE: finished=1 and busy=0, held until the next start; frame_err is held until the next ARM entry, then cleared.
REQ-025 busy=1 in ARM and CAPTURE only; write_en=0 outside CAPTURE, except for the final registered write the cycle after the transition.
REQ-026 Address arithmetic SHALL be 19-bit unsigned, computed incrementally (no multiplier); x is 10 bits and y is 9 bits.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, x=0, y=0, write_en=0, write_addr=0, raw_data=0, busy=0, finished=0 and frame_err=0.
REQ-028 Reset mid-capture SHALL abandon the frame; no write SHALL follow the reset release until a new start and vsync fall.
REQ-029 Reset deassertion SHALL be synchronised internally with a 2-flop release; the first state change is at the earliest 2 cycles after release.

Structure
REQ-030 Package raw_capture_pkg SHALL hold the state enum, FRAME_LEN=FRAME_W*FRAME_H, and ADDR_W=19.
REQ-031 One sub-module, pixel_pos_counter, SHALL hold the x/y counters and the incremental address, with inc_x/next_line/clear controls.
REQ-032 The camera inputs SHALL be registered once before edge detection (single clock domain; no CDC logic).

Verification (FRAME_W=8, FRAME_H=4)
REQ-033 Scenario 1: start; vsync 1->0; 4 lines of 8 href pixels with data=addr -> 32 writes at addr 0..31 with raw_data=addr, finished=1, frame_err=0.
REQ-034 Scenario 2: one line of 10 pixels -> pixels 8 and 9 are not written, frame_err=1, and the total write count stays 32.
REQ-035 Scenario 3: vsync rises after 2 lines -> DONE with 16 writes, frame_err=1, finished=1.
REQ-036 Scenario 4: start issued mid-frame, with href active and no vsync fall yet -> no writes until the next vsync fall, then a clean 32-write frame.
REQ-037 Scenario 5: reset=0 at pixel 13 -> all outputs are 0 immediately; after release, no writes until a new start and vsync fall.
REQ-038 Scenario 6: a start pulse during CAPTURE has no effect; a start in DONE clears finished and frame_err on ARM entry.
